data_source: RTL and testbench
==============================

DATA_SOURCE -- requirements
Module: data_source

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data word width.
REQ-002 The block SHALL have parameter LFSR_POLY, default 16'hB400, Galois LFSR tap mask.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-low reset; 0 = in reset.
REQ-006 start  input  1  one-cycle burst request, sampled only in IDLE.
REQ-007 mode  input  2  pattern select: 0 INCR, 1 LFSR, 2 CONST, 3 WALK.
REQ-008 seed  input  WIDTH  first word or pattern seed, captured with start.
REQ-009 len  input  8  burst beat count; 0 means 256.
REQ-010 data  output  WIDTH  current beat.
REQ-011 valid  output  1  data holds a beat.
REQ-012 ready  input  1  consumer accepts the beat when valid=1.
REQ-013 busy  output  1  high in RUN and DONE.
REQ-014 done  output  1  one-cycle pulse after the last beat transfers.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 at edge k SHALL capture mode, seed and len, and move to RUN with valid=1 and data=first word after edge k.
REQ-017 A transfer SHALL occur on any edge where valid=1 and ready=1.
REQ-018 While valid=1 and ready=0, data and valid SHALL hold stable.
REQ-019 After a non-final transfer, the next word SHALL appear at that same edge, giving zero bubbles at ready=1.
REQ-020 After the final transfer (beat count reaches len), the FSM SHALL enter DONE with valid=0 and done=1 for exactly one cycle, then return to IDLE.
REQ-021 data SHALL be 16'h0 whenever valid=0.
REQ-022 INCR SHALL emit seed, seed+1, and so on, modulo 2^WIDTH, so 16'hFFFF is followed by 16'h0000.
REQ-023 LFSR SHALL emit the seed, then each next word SHALL be (w>>1) XOR (w[0] ? LFSR_POLY : 0).
REQ-024 In LFSR mode, a seed of 0 SHALL be replaced by 16'h0001.
REQ-025 CONST SHALL emit seed on every beat.
REQ-026 WALK SHALL emit a one-hot word at bit seed[3:0], rotated left by one bit per beat, so bit 15 is followed by bit 0.
REQ-027 start SHALL be ignored in RUN and DONE.
REQ-028 A start in the DONE cycle SHALL be dropped.
REQ-029 The input mode, seed and len SHALL have no effect after capture.
REQ-030 The beat counter SHALL be 9 bits wide so that len=0 yields exactly 256 beats.

Reset
REQ-031 While reset=0, at each edge, the state SHALL go to IDLE and the outputs SHALL be data=0, valid=0, busy=0, done=0.
REQ-032 On the first edge with reset=1, data SHALL still be 16'h0, so that data is zero when reset rises.
REQ-033 Reset asserted mid-burst SHALL abort the burst without a done pulse.
REQ-034 After such an abort, no state SHALL persist into the next burst.

Structure
REQ-035 Package data_source_pkg SHALL hold the mode and state enums, the default LFSR_POLY and the 256-beat maximum constant.
REQ-036 Next-word generation SHALL be a combinational sub-module, data_source_pattern, with inputs mode and current word and output next word.
REQ-037 The FSM, counter and handshake logic SHALL reside in data_source.

Verification
REQ-038 Scenario: INCR, seed=16'hFFFE, len=4, ready=1 -> data FFFE, FFFF, 0000, 0001 on consecutive cycles, then done=1 for one cycle.
REQ-039 Scenario: LFSR, seed=0, len=3 -> 0001, B400, 5A00.
REQ-040 Scenario: CONST, seed=16'hA5A5, len=2, ready low for 3 cycles on beat 1 -> A5A5 held, exactly 2 transfers.
REQ-041 Scenario: WALK, seed=16'h000F, len=3 -> 8000, 0001, 0002.
REQ-042 Scenario: len=0, ready=1 -> exactly 256 transfers, then one done pulse; a start during RUN has no effect.
REQ-043 Scenario: reset=0 on beat 5 of a 10-beat burst -> valid=0 and data=0 next edge, no done pulse, data=0 on the reset release edge.
REQ-044 A concurrent checker SHALL verify that data==0 when reset rises and when valid=0.

Source files
------------

// File: rtl/data_source_pkg.sv
// Shared types and constants for the data_source burst generator.
package data_source_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_WALK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0] DEFAULT_LFSR_POLY = 16'hB400;
  localparam int          MAX_BEATS         = 256;

endpackage

// File: rtl/data_source_pattern.sv
// Combinational next-word generator: maps the current beat to the following one.
module data_source_pattern
  import data_source_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'(DEFAULT_LFSR_POLY)
) (
  input  mode_e            mode,
  input  logic [WIDTH-1:0] cur_word,
  output logic [WIDTH-1:0] next_word
);

  always_comb begin
    next_word = cur_word;
    case (mode)
      MODE_INCR: next_word = cur_word + WIDTH'(1);
      MODE_LFSR: next_word = (cur_word >> 1) ^ (cur_word[0] ? LFSR_POLY : '0);
      MODE_WALK: next_word = {cur_word[WIDTH-2:0], cur_word[WIDTH-1]};
      default:   next_word = cur_word;
    endcase
  end

endmodule

// File: rtl/data_source.sv
// Burst pattern source: captures a request in IDLE, streams len beats with
// valid/ready flow control, then pulses done for one cycle.
module data_source
  import data_source_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'(DEFAULT_LFSR_POLY)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [7:0]       len,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [8:0]       len_q, len_d;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] next_word;
  logic             last_beat;

  data_source_pattern #(
    .WIDTH     (WIDTH),
    .LFSR_POLY (LFSR_POLY)
  ) u_pattern (
    .mode      (mode_q),
    .cur_word  (word_q),
    .next_word (next_word)
  );

  // First beat derives from the live inputs since it is loaded on the start edge.
  always_comb begin
    first_word = seed;
    case (mode_e'(mode))
      MODE_LFSR: first_word = (seed == '0) ? WIDTH'(1) : seed;
      MODE_WALK: first_word = WIDTH'(1) << seed[3:0];
      default:   first_word = seed;
    endcase
  end

  assign last_beat = ((cnt_q + 9'd1) == len_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mode_d  = mode_e'(mode);
          word_d  = first_word;
          cnt_d   = '0;
          len_d   = (len == 8'd0) ? 9'(MAX_BEATS) : {1'b0, len};
        end
      end
      ST_RUN: begin
        if (ready) begin
          if (last_beat) begin
            state_d = ST_DONE;
          end else begin
            word_d = next_word;
            cnt_d  = cnt_q + 9'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Every register is cleared so an aborted burst leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_INCR;
      word_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign valid = (state_q == ST_RUN);
  assign data  = valid ? word_q : '0;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_data_source.sv
// Self-checking bench for data_source: queue-based burst model plus directed scenarios.
module tb_data_source;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] seed;
  logic [7:0]  len;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  data_source #(.WIDTH(16), .LFSR_POLY(16'hB400)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .seed  (seed),
    .len   (len),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: remaining words of the current burst, plus the pending done cycle.
  logic [15:0] mq[$];
  bit          m_done = 1'b0;
  logic [15:0] log_q[$];
  int          done_cnt = 0;
  logic        prev_rst = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void build(input logic [1:0] md, input logic [15:0] sd, input logic [7:0] ln);
    int          n;
    int          b;
    logic [15:0] w;
    n = (ln == 8'd0) ? 256 : int'(ln);
    b = int'(sd[3:0]);
    w = (sd == 16'h0) ? 16'h0001 : sd;
    for (int i = 0; i < n; i++) begin
      case (md)
        2'd0: mq.push_back(16'((int'(sd) + i) % 65536));
        2'd1: begin
          mq.push_back(w);
          w = (w >> 1) ^ (w[0] ? 16'hB400 : 16'h0000);
        end
        2'd2: mq.push_back(sd);
        default: mq.push_back(16'(1 << ((b + i) % 16)));
      endcase
    end
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (mq.size() > 0) begin
      if (ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end
    end else if (start) begin
      build(mode, seed, len);
    end
  end

  always @(negedge clk) begin
    bit          ev;
    logic [15:0] ed;
    ev = (mq.size() > 0);
    ed = ev ? mq[0] : 16'h0;
    chk("cyc_valid", {31'b0, valid}, {31'b0, ev});
    chk("cyc_data", {16'b0, data}, {16'b0, ed});
    chk("cyc_busy", {31'b0, busy}, {31'b0, ev | m_done});
    chk("cyc_done", {31'b0, done}, {31'b0, m_done});
    if (!valid) chk("idle_data_zero", {16'b0, data}, 32'h0);
    if (reset && !prev_rst) chk("rise_data_zero", {16'b0, data}, 32'h0);
    prev_rst = reset;
    if (done) done_cnt++;
    if (valid && ready && reset) log_q.push_back(data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] md, input logic [15:0] sd, input logic [7:0] ln);
    start = 1'b1;
    mode  = md;
    seed  = sd;
    len   = ln;
    tick();
    start = 1'b0;
    mode  = 2'($urandom);
    seed  = 16'($urandom);
    len   = 8'($urandom);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy || valid) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) chk({nm, "_timeout"}, 32'(n), 32'(0));
    tick();
    $display("burst %s: beats=%0d dones=%0d", nm, log_q.size(), done_cnt);
  endtask

  task automatic chk_log(input string nm, input logic [15:0] exp[$]);
    chk({nm, "_count"}, 32'(log_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk({nm, "_beat"}, (i < log_q.size()) ? {16'b0, log_q[i]} : 32'hxxxx_xxxx, {16'b0, exp[i]});
  endtask

  initial begin
    logic [15:0] exp_q[$];
    int          d0;
    int          n;
    reset = 1'b0;
    start = 1'b0;
    mode  = 2'd0;
    seed  = 16'h0;
    len   = 8'd0;
    ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_data", {16'b0, data}, 32'h0);
    reset = 1'b1;
    tick();

    // INCR wrap
    log_q.delete(); d0 = done_cnt;
    issue(2'd0, 16'hFFFE, 8'd4);
    wait_idle("incr");
    exp_q = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    chk_log("incr", exp_q);
    chk("incr_done", 32'(done_cnt - d0), 32'd1);

    // LFSR zero seed
    log_q.delete(); d0 = done_cnt;
    issue(2'd1, 16'h0000, 8'd3);
    wait_idle("lfsr");
    exp_q = '{16'h0001, 16'hB400, 16'h5A00};
    chk_log("lfsr", exp_q);
    chk("lfsr_done", 32'(done_cnt - d0), 32'd1);

    // CONST with backpressure, plus a start in the DONE cycle
    log_q.delete(); d0 = done_cnt;
    ready = 1'b0;
    issue(2'd2, 16'hA5A5, 8'd2);
    repeat (3) tick();
    ready = 1'b1;
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk("const_done_seen", {31'b0, done}, 32'd1);
    start = 1'b1; mode = 2'd0; seed = 16'h7777; len = 8'd5;
    tick();
    start = 1'b0;
    tick();
    chk("const_drop_valid", {31'b0, valid}, 32'h0);
    chk("const_drop_busy", {31'b0, busy}, 32'h0);
    wait_idle("const");
    exp_q = '{16'hA5A5, 16'hA5A5};
    chk_log("const", exp_q);
    chk("const_done", 32'(done_cnt - d0), 32'd1);

    // WALK wrap from bit 15
    log_q.delete(); d0 = done_cnt;
    issue(2'd3, 16'h000F, 8'd3);
    wait_idle("walk");
    exp_q = '{16'h8000, 16'h0001, 16'h0002};
    chk_log("walk", exp_q);
    chk("walk_done", 32'(done_cnt - d0), 32'd1);

    // len=0 means 256 beats; a start in RUN is ignored
    log_q.delete(); d0 = done_cnt;
    issue(2'd0, 16'h0010, 8'd0);
    repeat (100) tick();
    start = 1'b1; mode = 2'd2; seed = 16'hFFFF; len = 8'd1;
    tick();
    start = 1'b0;
    wait_idle("len256");
    chk("len256_count", 32'(log_q.size()), 32'd256);
    chk("len256_first", (log_q.size() > 0) ? {16'b0, log_q[0]} : 32'hxxxx_xxxx, 32'h0010);
    chk("len256_last", (log_q.size() > 255) ? {16'b0, log_q[255]} : 32'hxxxx_xxxx, 32'h010F);
    chk("len256_done", 32'(done_cnt - d0), 32'd1);

    // Reset on beat 5 of 10 aborts without done, then a clean burst follows
    log_q.delete(); d0 = done_cnt;
    issue(2'd0, 16'h0100, 8'd10);
    repeat (4) tick();
    reset = 1'b0;
    tick();
    chk("abort_valid", {31'b0, valid}, 32'h0);
    chk("abort_data", {16'b0, data}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("abort_release_data", {16'b0, data}, 32'h0);
    chk("abort_count", 32'(log_q.size()), 32'd4);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    issue(2'd2, 16'h1234, 8'd1);
    wait_idle("post_abort");
    chk("post_abort_count", 32'(log_q.size()), 32'd5);
    chk("post_abort_word", (log_q.size() > 4) ? {16'b0, log_q[4]} : 32'hxxxx_xxxx, 32'h1234);
    chk("post_abort_done", 32'(done_cnt - d0), 32'd1);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
